// File: rtl/btn_debounce_step_pkg.sv
// Shared definitions for the push-button debounce / step-pulse front end.
//   state_t  : 2-bit FSM state encoding (RELEASED=0, PRESS_CHK=1, PRESSED=2,
//              RELEASE_CHK=3)
//   max_int  : constant helper used to size the repeat counter
package btn_debounce_step_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/btn_debounce_step_sync_2ff.sv
// Reusable two-flop synchroniser for a single asynchronous bit.
//   clk : sampling clock
//   rst : synchronous active-high reset; both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronised output (two cycles of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1_r;
  logic sync2_r;

  // Two-stage metastability filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= RESET_VAL;
      sync2_r <= RESET_VAL;
    end else begin
      sync1_r <= d;
      sync2_r <= sync1_r;
    end
  end

  assign q = sync2_r;

endmodule

// File: rtl/btn_debounce_step.sv
// Push-button front end: synchronises a raw button, debounces it with a
// cycle-count qualifier and emits single-cycle press / release / auto-repeat
// pulses. step_pulse (press OR repeat) drives a downstream counter enable.
//   clk           : clock
//   rst           : synchronous active-high reset
//   btn_in        : raw asynchronous button, active-high
//   btn_level     : debounced level (1 while PRESSED or RELEASE_CHK)
//   press_pulse   : one cycle on an accepted press
//   release_pulse : one cycle on an accepted release
//   repeat_pulse  : one cycle per auto-repeat while held
//   step_pulse    : press_pulse | repeat_pulse
module btn_debounce_step
  import btn_debounce_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 100000,
  parameter int REPEAT_EN            = 1,
  parameter int REPEAT_DELAY_CYCLES  = 50000000,
  parameter int REPEAT_PERIOD_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step_pulse
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_MAX = max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE      = DB_W'(1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);

  logic sync2_s;

  state_t           state_r,   state_nx;
  logic [DB_W-1:0]  db_cnt_r,  db_cnt_nx;
  logic [RPT_W-1:0] rpt_cnt_r, rpt_cnt_nx;
  // Set once the initial repeat delay has elapsed; selects the period threshold.
  logic             armed_r,   armed_nx;

  logic level_r,   level_nx;
  logic press_r,   press_nx;
  logic release_r, release_nx;
  logic repeat_r,  repeat_nx;
  logic step_r,    step_nx;

  logic [RPT_W-1:0] rpt_last_s;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (sync2_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RELEASED;
      db_cnt_r  <= '0;
      rpt_cnt_r <= '0;
      armed_r   <= 1'b0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      repeat_r  <= 1'b0;
      step_r    <= 1'b0;
    end else begin
      state_r   <= state_nx;
      db_cnt_r  <= db_cnt_nx;
      rpt_cnt_r <= rpt_cnt_nx;
      armed_r   <= armed_nx;
      level_r   <= level_nx;
      press_r   <= press_nx;
      release_r <= release_nx;
      repeat_r  <= repeat_nx;
      step_r    <= step_nx;
    end
  end

  // Next-state, counter updates and next-cycle pulse values.
  always_comb begin
    state_nx   = state_r;
    db_cnt_nx  = db_cnt_r;
    rpt_cnt_nx = rpt_cnt_r;
    armed_nx   = armed_r;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    repeat_nx  = 1'b0;

    if (armed_r) begin
      rpt_last_s = PERIOD_LAST;
    end else begin
      rpt_last_s = DELAY_LAST;
    end

    case (state_r)
      RELEASED: begin
        if (sync2_s) begin
          state_nx  = PRESS_CHK;
          db_cnt_nx = '0;
        end else begin
          state_nx  = RELEASED;
        end
      end

      PRESS_CHK: begin
        if (!sync2_s) begin
          state_nx = RELEASED;
        end else if (db_cnt_r == DB_LAST) begin
          state_nx   = PRESSED;
          press_nx   = 1'b1;
          rpt_cnt_nx = '0;
          armed_nx   = 1'b0;
        end else begin
          db_cnt_nx = db_cnt_r + DB_ONE;
        end
      end

      PRESSED: begin
        // A falling input takes priority over a repeat due on the same edge.
        if (!sync2_s) begin
          state_nx  = RELEASE_CHK;
          db_cnt_nx = '0;
        end else if (REPEAT_EN != 0) begin
          if (rpt_cnt_r == rpt_last_s) begin
            repeat_nx  = 1'b1;
            rpt_cnt_nx = '0;
            armed_nx   = 1'b1;
          end else begin
            rpt_cnt_nx = rpt_cnt_r + RPT_ONE;
          end
        end else begin
          rpt_cnt_nx = rpt_cnt_r;
        end
      end

      RELEASE_CHK: begin
        // Returning to PRESSED keeps the repeat counter where it was frozen.
        if (sync2_s) begin
          state_nx = PRESSED;
        end else if (db_cnt_r == DB_LAST) begin
          state_nx   = RELEASED;
          release_nx = 1'b1;
        end else begin
          db_cnt_nx = db_cnt_r + DB_ONE;
        end
      end

      default: begin
        state_nx   = RELEASED;
        db_cnt_nx  = '0;
        rpt_cnt_nx = '0;
        armed_nx   = 1'b0;
      end
    endcase

    level_nx = (state_nx == PRESSED) || (state_nx == RELEASE_CHK);
    step_nx  = press_nx | repeat_nx;
  end

  assign btn_level     = level_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign repeat_pulse  = repeat_r;
  assign step_pulse    = step_r;

endmodule

// File: tb/tb_btn_debounce_step.sv
module tb_btn_debounce_step;

  localparam int D      = 4;
  localparam int DELAY  = 8;
  localparam int PERIOD = 3;
  localparam int REP_EN = 1;

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;
  logic step_pulse;

  btn_debounce_step #(
    .DEBOUNCE_CYCLES     (D),
    .REPEAT_EN           (REP_EN),
    .REPEAT_DELAY_CYCLES (DELAY),
    .REPEAT_PERIOD_CYCLES(PERIOD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .step_pulse   (step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector order: {level, press, release, repeat, step}
  logic [4:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int model_steps = 0;
  int dut_steps   = 0;
  int press_seen  = 0;
  int repeat_seen = 0;
  int release_seen = 0;
  bit checking = 1'b0;

  // Reference model: the FSM sees the button two edges late; an edge is
  // accepted after D+1 consecutive disagreeing samples; repeats fire when the
  // count of held (agreeing, non-checking) edges since the press equals
  // DELAY + m*PERIOD.
  initial begin : model
    logic s1, s2, sample, lvl, p, r, rp;
    int streak, held;
    s1 = 1'b0; s2 = 1'b0; lvl = 1'b0; streak = 0; held = 0;
    forever begin
      @(posedge clk);
      cycle++;
      if (checking) begin
        p = 1'b0; r = 1'b0; rp = 1'b0;
        if (rst) begin
          s1 = 1'b0; s2 = 1'b0; lvl = 1'b0; streak = 0; held = 0;
        end else begin
          sample = s2;
          s2 = s1;
          s1 = btn_in;
          if (sample != lvl) begin
            streak++;
            if (streak == D + 1) begin
              lvl = ~lvl;
              streak = 0;
              if (lvl) begin
                p = 1'b1;
                held = 0;
              end else begin
                r = 1'b1;
              end
            end
          end else begin
            if (lvl && streak == 0) begin
              held++;
              if (REP_EN != 0 && held >= DELAY && ((held - DELAY) % PERIOD) == 0)
                rp = 1'b1;
            end
            streak = 0;
          end
        end
        if (p || rp) model_steps++;
        exp_q.push_back({lvl, p, r, rp, p | rp});
      end
    end
  end

  // Monitor: pops one expected vector per clock and compares.
  initial begin : monitor
    logic [4:0] got, exp;
    forever begin
      @(posedge clk);
      #1;
      if (checking) begin
        got = {btn_level, press_pulse, release_pulse, repeat_pulse, step_pulse};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty cycle %0d: got %b, no expected entry", cycle, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL outputs cycle %0d: lvl/prs/rel/rpt/stp got %b required %b", cycle, got, exp);
          end
        end
        if (step_pulse === 1'b1) dut_steps++;
        if (press_pulse === 1'b1) press_seen++;
        if (repeat_pulse === 1'b1) repeat_seen++;
        if (release_pulse === 1'b1) release_seen++;
      end
    end
  end

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      btn_in = v;
      @(negedge clk);
    end
  endtask

  task automatic pulse_rst(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : stimulus
    int len;
    logic v;
    rst = 1'b1;
    btn_in = 1'b0;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle, clean press with long hold (repeats), release glitch, release.
    hold(1'b0, 6);
    hold(1'b1, 38);
    hold(1'b0, 2);
    hold(1'b1, 6);
    hold(1'b0, 12);

    // Bouncing input that never qualifies.
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 3);
      hold(1'b0, 1);
    end
    hold(1'b0, 8);

    // Drop during a due repeat region, then reset while held.
    hold(1'b1, 20);
    pulse_rst(2);
    hold(1'b1, 16);
    hold(1'b0, 10);

    // Randomised segments with occasional resets.
    for (int i = 0; i < 120; i++) begin
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(10, 30);
      else len = $urandom_range(1, 7);
      if ($urandom_range(0, 24) == 0) pulse_rst($urandom_range(1, 3));
      hold(v, len);
    end
    hold(1'b0, 12);

    @(posedge clk);
    #3;
    checking = 1'b0;

    checks++;
    if (dut_steps != model_steps) begin
      errors++;
      $display("FAIL step_count: got %0d required %0d", dut_steps, model_steps);
    end
    checks++;
    if (press_seen == 0 || repeat_seen == 0 || release_seen == 0) begin
      errors++;
      $display("FAIL pulse_coverage: press %0d repeat %0d release %0d, required all nonzero",
               press_seen, repeat_seen, release_seen);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
